// File: rtl/tlul_slave_led_ctrl.sv
// TL-UL slave LED bank with set/clear/toggle aliases
// and a prescaled hardware blink engine.
module tlul_slave_led_ctrl #(
  parameter int NUM_LEDS = 8,
  parameter int ADDR_W   = 5,
  parameter int SOURCE_W = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_a_valid,
  output logic                o_a_ready,
  input  logic [2:0]          i_a_opcode,
  input  logic [2:0]          i_a_param,
  input  logic [1:0]          i_a_size,
  input  logic [SOURCE_W-1:0] i_a_source,
  input  logic [ADDR_W-1:0]   i_a_address,
  input  logic [3:0]          i_a_mask,
  input  logic [31:0]         i_a_data,
  output logic                o_d_valid,
  input  logic                i_d_ready,
  output logic [2:0]          o_d_opcode,
  output logic [1:0]          o_d_param,
  output logic [1:0]          o_d_size,
  output logic [SOURCE_W-1:0] o_d_source,
  output logic [31:0]         o_d_data,
  output logic                o_d_error,
  output logic [NUM_LEDS-1:0] o_leds
);

  typedef enum logic [2:0] {
    R_OUT   = 3'd0,
    R_SET   = 3'd1,
    R_CLR   = 3'd2,
    R_TOG   = 3'd3,
    R_BMASK = 3'd4,
    R_BDIV  = 3'd5,
    R_RSV6  = 3'd6,
    R_RSV7  = 3'd7
  } reg_e;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  logic                d_valid_q;
  logic [2:0]          d_opcode_q;
  logic [1:0]          d_size_q;
  logic [SOURCE_W-1:0] d_source_q;
  logic [31:0]         d_data_q;
  logic                d_error_q;

  logic [NUM_LEDS-1:0] led_q;
  logic [NUM_LEDS-1:0] bmask_q;
  logic [15:0]         bdiv_q;
  logic [15:0]         cnt_q;

  reg_e                sel;
  logic                accept;
  logic                is_get;
  logic                is_put;
  logic                err;
  logic                wr;
  logic                led_wr;
  logic                div_wr;
  logic                tick;
  logic [31:0]         lane;
  logic [31:0]         wdata;
  logic [NUM_LEDS-1:0] wd_led;
  logic [NUM_LEDS-1:0] lane_led;
  logic [NUM_LEDS-1:0] led_d;
  logic [31:0]         rdata;
  logic                unused;

  assign o_a_ready = !d_valid_q;
  assign accept    = i_a_valid && !d_valid_q;
  assign sel       = reg_e'(i_a_address[4:2]);

  assign is_get = (i_a_opcode == OP_GET);
  assign is_put = (i_a_opcode == OP_PUT_FULL)
               || (i_a_opcode == OP_PUT_PART);

  assign err = !(is_get || is_put)
            || (sel == R_RSV6)
            || (sel == R_RSV7);

  assign wr     = accept && is_put && !err;
  assign led_wr = wr && ((sel == R_OUT) || (sel == R_SET)
                      || (sel == R_CLR) || (sel == R_TOG));
  assign div_wr = wr && (sel == R_BDIV);

  assign lane = {{8{i_a_mask[3]}}, {8{i_a_mask[2]}},
                 {8{i_a_mask[1]}}, {8{i_a_mask[0]}}};
  assign wdata    = i_a_data & lane;
  assign wd_led   = wdata[NUM_LEDS-1:0];
  assign lane_led = lane[NUM_LEDS-1:0];

  assign tick = (bdiv_q != 16'd0) && (cnt_q == bdiv_q);

  // A bus write to the LED aliases overrides a same-edge blink tick.
  always_comb begin
    led_d = led_q;
    if (led_wr) begin
      unique case (1'b1)
        sel == R_OUT: led_d = (led_q & ~lane_led) | wd_led;
        sel == R_SET: led_d = led_q | wd_led;
        sel == R_CLR: led_d = led_q & ~wd_led;
        sel == R_TOG: led_d = led_q ^ wd_led;
      endcase
    end else if (tick) begin
      led_d = led_q ^ bmask_q;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel == R_OUT)   rdata[NUM_LEDS-1:0] = led_q;
    if (sel == R_BMASK) rdata[NUM_LEDS-1:0] = bmask_q;
    if (sel == R_BDIV)  rdata[15:0]         = bdiv_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      led_q   <= '0;
      bmask_q <= '0;
      bdiv_q  <= '0;
    end else begin
      led_q <= led_d;
      if (wr && (sel == R_BMASK))
        bmask_q <= (bmask_q & ~lane_led) | wd_led;
      if (div_wr)
        bdiv_q <= (bdiv_q & ~lane[15:0]) | wdata[15:0];
    end
  end

  // Any accepted BLINK_DIV write restarts the period, mask or not.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else if (div_wr || (bdiv_q == 16'd0) || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else if (accept) begin
      d_valid_q  <= 1'b1;
      d_opcode_q <= is_get ? OP_ACK_DATA : OP_ACK;
      d_size_q   <= i_a_size;
      d_source_q <= i_a_source;
      d_data_q   <= (is_get && !err) ? rdata : 32'd0;
      d_error_q  <= err;
    end else if (d_valid_q && i_d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  assign o_d_valid  = d_valid_q;
  assign o_d_opcode = d_opcode_q;
  assign o_d_param  = 2'd0;
  assign o_d_size   = d_size_q;
  assign o_d_source = d_source_q;
  assign o_d_data   = d_data_q;
  assign o_d_error  = d_error_q;
  assign o_leds     = led_q;

  assign unused = ^{i_a_param, i_a_address, wdata, lane};

endmodule

// File: tb/tb_tlul_slave_led_ctrl.sv
// Directed and randomized bench for tlul_slave_led_ctrl
// against a behavioural register-file model.
module tb_tlul_slave_led_ctrl;

  localparam int NL = 8;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_op;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [3:0]  a_src;
  logic [4:0]  a_addr;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_op;
  logic [1:0]  d_param;
  logic [1:0]  d_size;
  logic [3:0]  d_src;
  logic [31:0] d_data;
  logic        d_err;
  logic [NL-1:0] leds;

  int checks = 0;
  int failures = 0;

  tlul_slave_led_ctrl #(.NUM_LEDS(NL), .ADDR_W(5), .SOURCE_W(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(a_ready),
    .i_a_opcode(a_op), .i_a_param(a_param), .i_a_size(a_size),
    .i_a_source(a_src), .i_a_address(a_addr), .i_a_mask(a_mask),
    .i_a_data(a_data),
    .o_d_valid(d_valid), .i_d_ready(d_ready),
    .o_d_opcode(d_op), .o_d_param(d_param), .o_d_size(d_size),
    .o_d_source(d_src), .o_d_data(d_data), .o_d_error(d_err),
    .o_leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: plain integers following the register map rules.
  logic [31:0] lm = (32'd1 << NL) - 32'd1;
  logic [31:0] m_led, m_bmask, m_ddata;
  int          m_div, m_cnt;
  bit          m_dv, m_derr, last_acc;
  logic [2:0]  m_dop;
  logic [3:0]  m_dsrc;
  logic [1:0]  m_dsize;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led = 0; m_bmask = 0; m_div = 0; m_cnt = 0;
    m_dv = 0; m_derr = 0; m_ddata = 0; m_dop = 0;
    m_dsrc = 0; m_dsize = 0; last_acc = 0;
  endtask

  task automatic model_step();
    logic [31:0] bm, wd, rd;
    int sel;
    bit g, p, e, acc, tk, wr;
    acc = a_valid && !m_dv;
    sel = int'(a_addr[4:2]);
    g = (a_op == 3'd4);
    p = (a_op <= 3'd1);
    e = !(g || p) || sel > 5;
    wr = acc && p && !e;
    bm = {{8{a_mask[3]}}, {8{a_mask[2]}}, {8{a_mask[1]}}, {8{a_mask[0]}}};
    wd = a_data & bm;
    tk = (m_div != 0) && (m_cnt == m_div);
    case (sel)
      0: rd = m_led;
      4: rd = m_bmask;
      5: rd = 32'(m_div);
      default: rd = 0;
    endcase
    if (wr && sel == 5) m_cnt = 0;
    else if (m_div == 0) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % (m_div + 1);
    if (tk && !(wr && sel <= 3)) m_led = m_led ^ m_bmask;
    if (wr) begin
      case (sel)
        0: m_led = (m_led & ~bm) | wd;
        1: m_led = m_led | wd;
        2: m_led = m_led & ~wd;
        3: m_led = m_led ^ wd;
        4: m_bmask = ((m_bmask & ~bm) | wd) & lm;
        5: m_div = int'(((32'(m_div) & ~bm) | wd) & 32'hFFFF);
        default: ;
      endcase
    end
    m_led = m_led & lm;
    last_acc = acc;
    if (acc) begin
      m_dv = 1;
      m_dop = g ? 3'd1 : 3'd0;
      m_derr = e;
      m_ddata = (g && !e) ? rd : 32'd0;
      m_dsrc = a_src;
      m_dsize = a_size;
    end else if (m_dv && d_ready) begin
      m_dv = 0;
    end
  endtask

  task automatic check_all();
    chk("leds", 32'(leds), m_led);
    chk("d_valid", 32'(d_valid), 32'(m_dv));
    chk("a_ready", 32'(a_ready), 32'(!m_dv));
    if (m_dv) begin
      chk("d_opcode", 32'(d_op), 32'(m_dop));
      chk("d_error", 32'(d_err), 32'(m_derr));
      chk("d_data", d_data, m_ddata);
      chk("d_source", 32'(d_src), 32'(m_dsrc));
      chk("d_size", 32'(d_size), 32'(m_dsize));
      chk("d_param", 32'(d_param), 32'd0);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic xact(input logic [2:0] op, input logic [4:0] addr,
                      input logic [3:0] msk, input logic [31:0] data,
                      output logic [2:0] rop, output logic rerr,
                      output logic [31:0] rdat);
    int n;
    logic [3:0] src;
    src = 4'($urandom);
    a_op = op; a_addr = addr; a_mask = msk; a_data = data;
    a_src = src; a_size = 2'($urandom); a_valid = 1; d_ready = 0;
    n = 0;
    do begin cycle(); n++; end while (!last_acc && n < 8);
    chk("accept", 32'(last_acc), 32'd1);
    a_valid = 0;
    chk("resp_latency", 32'(d_valid), 32'd1);
    chk("resp_source", 32'(d_src), 32'(src));
    rop = d_op; rerr = d_err; rdat = d_data;
    d_ready = 1;
    cycle();
    d_ready = 0;
  endtask

  initial begin : main
    logic [2:0]  rop;
    logic        rerr;
    logic [31:0] rdat;
    logic [NL-1:0] prev;
    logic [2:0]  ops [6];
    int n, changes;
    ops = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd2, 3'd7};

    a_param = 0; a_size = 0; a_src = 0; a_addr = 0;
    a_mask = 4'hF; a_data = 32'hFFFF_FFFF; a_op = 3'd0;
    d_ready = 0;
    a_valid = 1;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_d_fields", {d_op, d_size, d_src, d_err, d_param}, 32'd0);
    chk("rst_d_data", d_data, 32'd0);
    a_valid = 0;
    rst_n = 1;
    cycle();

    xact(3'd4, 5'h00, 4'hF, 0, rop, rerr, rdat);
    chk("rst_get_op", 32'(rop), 32'd1);
    chk("rst_get_data", rdat, 32'd0);

    xact(3'd0, 5'h00, 4'hF, 32'hA5, rop, rerr, rdat);
    chk("put_leds", 32'(leds), 32'hA5);
    chk("put_ack", 32'(rop), 32'd0);
    xact(3'd0, 5'h04, 4'hF, 32'h0F, rop, rerr, rdat);
    chk("set_leds", 32'(leds), 32'hAF);
    xact(3'd0, 5'h08, 4'hF, 32'h81, rop, rerr, rdat);
    chk("clr_leds", 32'(leds), 32'h2E);
    xact(3'd0, 5'h0C, 4'hF, 32'hFF, rop, rerr, rdat);
    chk("tog_leds", 32'(leds), 32'hD1);

    xact(3'd0, 5'h00, 4'hF, 32'h0F, rop, rerr, rdat);
    xact(3'd1, 5'h00, 4'b0010, 32'h0000FF00, rop, rerr, rdat);
    chk("partial_leds", 32'(leds), 32'h0F);

    xact(3'd0, 5'h10, 4'hF, 32'h03, rop, rerr, rdat);
    xact(3'd0, 5'h00, 4'hF, 32'h00, rop, rerr, rdat);
    xact(3'd0, 5'h14, 4'hF, 32'h03, rop, rerr, rdat);
    changes = 0;
    for (int i = 0; i < 12; i++) begin
      prev = leds;
      cycle();
      if (leds != prev) changes++;
    end
    chk("blink_ticks", 32'(changes), 32'd3);

    n = 0;
    while (m_cnt != m_div && n < 10) begin cycle(); n++; end
    chk("tick_align", 32'(m_cnt), 32'(m_div));
    prev = leds;
    a_op = 3'd0; a_addr = 5'h0C; a_mask = 4'hF; a_data = 0;
    a_valid = 1;
    cycle();
    chk("tog_beats_tick", 32'(leds), 32'(prev));
    a_valid = 0; d_ready = 1;
    cycle();
    d_ready = 0;

    a_op = 3'd4; a_addr = 5'h10; a_mask = 4'hF; a_src = 4'h9;
    a_valid = 1;
    cycle();
    a_addr = 5'h00;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_data", d_data, 32'h3);
      chk("bp_ready", 32'(a_ready), 32'd0);
    end
    a_valid = 0; d_ready = 1;
    cycle();
    chk("bp_done", 32'(d_valid), 32'd0);
    d_ready = 0;

    xact(3'd0, 5'h14, 4'hF, 32'h0, rop, rerr, rdat);
    prev = leds;
    xact(3'd0, 5'h18, 4'hF, 32'hFFFF_FFFF, rop, rerr, rdat);
    chk("err_put_flag", 32'(rerr), 32'd1);
    chk("err_put_op", 32'(rop), 32'd0);
    xact(3'd2, 5'h00, 4'hF, 32'h0, rop, rerr, rdat);
    chk("err_op2_flag", 32'(rerr), 32'd1);
    chk("err_leds", 32'(leds), 32'(prev));
    xact(3'd4, 5'h1C, 4'hF, 0, rop, rerr, rdat);
    chk("err_get_op", 32'(rop), 32'd1);
    chk("err_get_flag", 32'(rerr), 32'd1);
    chk("err_get_data", rdat, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      a_valid = ($urandom % 3) != 0;
      a_op = ops[$urandom % 6];
      a_addr = 5'($urandom);
      a_mask = 4'($urandom);
      a_data = $urandom;
      if (a_addr[4:2] == 3'd5) a_data = a_data & 32'h7;
      a_src = 4'($urandom);
      a_size = 2'($urandom);
      d_ready = ($urandom % 2) != 0;
      cycle();
    end

    a_valid = 1; d_ready = 0; a_op = 3'd4; a_addr = 5'h00;
    n = 0;
    while (!m_dv && n < 4) begin cycle(); n++; end
    #3;
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst_d_valid", 32'(d_valid), 32'd0);
    chk("mid_rst_leds", 32'(leds), 32'd0);
    chk("mid_rst_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;
    a_valid = 0;
    rst_n = 1;
    cycle();
    chk("post_rst_idle", 32'(d_valid), 32'd0);
    xact(3'd4, 5'h14, 4'hF, 0, rop, rerr, rdat);
    chk("post_rst_div", rdat, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlul_slave_led_ctrl.md
# tlul_slave_led_ctrl

TileLink-UL (TL-UL) slave that owns a bank of up to 32 LED outputs behind a small memory-mapped register file. Bus masters can write, set, clear and toggle LEDs atomically, and can program a hardware blink engine that toggles selected LEDs at a programmable rate. It is the next-generation, width-parametrised LED peripheral: it sits on the TL-UL crossbar and replaces the plain 8-bit LED latch.

## Interface
Parameters:
- NUM_LEDS, 8: number of LED outputs; legal range 1..32.
- ADDR_W, 5: width of `i_a_address`; must be at least 5.
- SOURCE_W, 4: width of the TL source ID.

Ports (one clock domain; reset is asynchronous and active-low):
- i_clk  in  1  the single clock; all state changes on its rising edge.
- i_reset_n  in  1  asynchronous reset, active low.
- i_a_valid  in  1  A-channel request valid.
- o_a_ready  out  1  A-channel ready.
- i_a_opcode  in  3  0 = PutFullData, 1 = PutPartialData, 4 = Get.
- i_a_param  in  3  ignored.
- i_a_size  in  2  echoed on D; not checked.
- i_a_source  in  SOURCE_W  echoed on D.
- i_a_address  in  ADDR_W  byte address; bits [4:2] select the register; other bits are ignored (aliasing).
- i_a_mask  in  4  byte-lane write enables.
- i_a_data  in  32  write data.
- o_d_valid  out  1  D-channel response valid.
- i_d_ready  in  1  D-channel ready.
- o_d_opcode  out  3  0 = AccessAck, 1 = AccessAckData.
- o_d_param  out  2  constant 0.
- o_d_size  out  2  captured `a_size`.
- o_d_source  out  SOURCE_W  captured `a_source`.
- o_d_data  out  32  read data; 0 for writes and errors.
- o_d_error  out  1  error flag for the response.
- o_leds  out  NUM_LEDS  the LED_OUT register, driven directly from flops.

## Operation
Register map (word offset: register, access):
- 0x00 LED_OUT, RW: current LED state.
- 0x04 LED_SET, W1S: set the LED_OUT bits written as 1; reads 0.
- 0x08 LED_CLR, W1C: clear the LED_OUT bits written as 1; reads 0.
- 0x0C LED_TOG, W1T: toggle the LED_OUT bits written as 1; reads 0.
- 0x10 BLINK_MASK, RW: LEDs toggled by the blink engine.
- 0x14 BLINK_DIV, RW, 16 bits in [15:0]: blink period control.
- 0x18 and 0x1C: unmapped; any access returns an error.

Write rules:
- Every write honours `i_a_mask` per byte lane, for both PutFullData and PutPartialData.
- LED bits at index NUM_LEDS and above are not stored and read as 0.
- BLINK_DIV bits [31:16] read as 0.

Blink engine:
- A 16-bit prescaler counts up every cycle while BLINK_DIV is nonzero.
- When the count equals BLINK_DIV, the counter wraps to 0 and the engine issues a tick: LED_OUT ^= BLINK_MASK.
- BLINK_DIV = 0 holds the counter at 0 and disables ticks.
- Any accepted write to BLINK_DIV clears the counter, even when the byte mask is 0.
- The tick period is BLINK_DIV + 1 cycles.

Priority and error handling:
- If a tick and an accepted write to LED_OUT, LED_SET, LED_CLR or LED_TOG land on the same edge, the bus write wins and that tick is dropped.
- Errors are raised for an unmapped offset, or for an opcode outside {0, 1, 4}.
- An error response has `o_d_error` = 1 and `o_d_data` = 0, and the request causes no state change.
- An erroring Get still returns AccessAckData; any other erroring request returns AccessAck.

Response control: a single-entry response register holds at most one outstanding transaction.

## Timing
- During reset, and after reset, all registers, the prescaler, `o_leds` and `o_d_valid` are 0.
- All D-channel fields are 0 at reset.
- `o_a_ready` = !`o_d_valid` (combinational from flops). Maximum throughput is one transaction per 2 cycles.
- A request is accepted on an edge where `i_a_valid` and `o_a_ready` are both 1. Call that edge N.
- Register updates and the new `o_leds` value are visible after edge N.
- `o_d_valid` rises after edge N, which gives 1-cycle latency.
- Read data is the register value before edge N; a tick occurring on edge N is not reflected in it.
- All D fields stay stable while `o_d_valid` is 1 and `i_d_ready` is 0.
- `o_d_valid` clears on the edge where `i_d_ready` is 1; the next request can then be accepted on the following edge.
- Asserting reset mid-transaction drops the pending response immediately and clears all state. No response is issued afterwards.

## Test plan
- Reset check: assert reset with `i_a_valid` = 1. Expect `o_leds` = 0, `o_d_valid` = 0 and `o_a_ready` = 1. After release, Get 0x00 returns AccessAckData with data 0.
- Plain write and set/clear/toggle: with NUM_LEDS = 8, Put 0x00 = 0xA5, then SET 0x0F, CLR 0x81, TOG 0xFF.
  - Expect `o_leds` = 0xA5, 0xAF, 0x2E, 0xD1 in turn.
  - Each write gets AccessAck with the source echoed, 1 cycle after acceptance.
- Partial write: PutPartialData 0x00 = 0x0000FF00 with mask 0b0010 while LED_OUT = 0x0F. Expect `o_leds` = 0x0F; bit 8 and above are not stored.
- Blink: BLINK_MASK = 0x03, BLINK_DIV = 3, LED_OUT = 0.
  - Expect `o_leds` to alternate between 0x03 and 0x00 every 4 cycles.
  - A TOG write landing on a tick edge suppresses that tick.
- Backpressure: Get 0x10 with `i_d_ready` held low for 5 cycles.
  - Expect `o_d_valid` and the D fields to stay stable, and `o_a_ready` = 0.
  - The response completes on the first edge where `i_d_ready` = 1.
- Errors:
  - Put 0x18 returns AccessAck with `o_d_error` = 1, and no state change.
  - Opcode 2 returns an error.
  - Get 0x1C returns AccessAckData with `o_d_error` = 1 and data 0.
